osd_vram_wr_arbiter: RTL and testbench
======================================

# osd_vram_wr_arbiter

Shares the single OSD character-VRAM write port between several writers: the init/clear sequencer (requester 0), the batch command executor, and live-update writers. It sits directly in front of the VRAM write port. Requester 0 gets fixed priority; the others are served round-robin. Each grant is a locked burst that ends on a `last` beat. Writes are gated by an external write-allow window, and out-of-range addresses are rejected.

## Interface

Parameters:
- `NUM_REQ`, 3: number of requesters (2..8); index 0 is the priority requester.
- `COLS`, 40: OSD columns.
- `ROWS`, 20: OSD rows; `DEPTH = COLS*ROWS` is the valid address range.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `wr_allow`  in  1  write window (e.g. blanking); 0 stalls all acceptance.
- `req_valid`  in  NUM_REQ  per-requester beat valid.
- `req_ready`  out  NUM_REQ  per-requester beat accept (combinational).
- `req_addr`  in  NUM_REQ*16  packed addresses; requester i uses bits [16i+15:16i].
- `req_data`  in  NUM_REQ*8  packed chars; requester i uses bits [8i+7:8i].
- `req_last`  in  NUM_REQ  marks the final beat of a burst.
- `vram_we`  out  1  registered write strobe.
- `vram_addr`  out  16  registered write address.
- `vram_data`  out  8  registered write data.
- `busy`  out  1  high while a burst lock is held.
- `owner`  out  $clog2(NUM_REQ)  current or last granted requester.
- `drop_count`  out  8  saturating count of rejected out-of-range beats.

## Operation

- States: S_IDLE, S_LOCK.
- A beat is accepted when `req_valid[i] && req_ready[i]`. At most one `req_ready` bit is high in any cycle.
- In S_IDLE with `wr_allow=1`:
  - If `req_valid[0]`, the winner is 0.
  - Otherwise, the winner is the first valid requester in 1..NUM_REQ-1, searching cyclically from `rr_ptr+1` and skipping 0.
  - The winner's `req_ready` is asserted in the same cycle, so its first beat is accepted immediately.
  - The accepted beat updates `owner` to the winner.
  - If that beat has `last=0`, go to S_LOCK.
- In S_LOCK, only `owner` can be accepted, and only when `wr_allow=1`. Requester 0 does not preempt a lock.
  - An accepted beat with `last=1` returns to S_IDLE.
  - While locked, `req_valid[owner]` deasserting does not release the lock. There is no timeout.
- `rr_ptr` updates to the owner when a burst from requester 1..NUM_REQ-1 ends, including single-beat bursts. Reset value is 0, so the first round-robin search starts at 1.
- Accepted beat with `addr < DEPTH`: next cycle `vram_we=1` with that addr/data.
- Accepted beat with `addr >= DEPTH`:
  - The beat is still accepted, and it still counts toward `last`.
  - Next cycle `vram_we=0`.
  - `drop_count` increments, saturating at 255.
- With no accepted beat, `vram_we=0` next cycle. `vram_addr` and `vram_data` hold their last values.
- `busy = (state == S_LOCK)`.

## Timing

- Reset values: `vram_we=0`, `vram_addr=0`, `vram_data=0`, `busy=0`, `owner=0`, `drop_count=0`, `rr_ptr=0`, state S_IDLE. `req_ready` is 0 in reset.
- Latency: an accepted beat appears on the VRAM port exactly 1 cycle later. Throughput is 1 beat/cycle within a burst.
- Back-to-back bursts: the cycle after a `last` beat, S_IDLE arbitrates again, so there is no bubble.
- `wr_allow` falling mid-burst: `req_ready=0` and the lock is held. Acceptance resumes on the first cycle `wr_allow=1`.
- `rst` mid-burst: immediate return to the reset values; the lock is released. The requester must restart its burst.
- Simultaneous `req_valid[0]` and other requests in S_IDLE: 0 wins. The others wait without losing their round-robin position.

## Test plan

- Single writer. Requester 1 sends 3 beats, addr 5/6/7, data 0x41/0x42/0x43, last on the 3rd → `vram_we` pulses on 3 consecutive cycles, each 1 cycle after its beat; `busy` is high after beat 1 and low after beat 3.
- Priority. Requesters 0 and 2 are valid in the same idle cycle → 0 is granted first. Requester 2's burst starts the cycle after 0's `last`.
- Round-robin. Requesters 1 and 2 send single-beat bursts continuously → grants alternate 1, 2, 1, 2 with no idle cycles.
- Lock. Requester 1 is mid-burst when requester 0 raises valid → requester 0 waits until requester 1's `last` beat, then is granted.
- Out-of-range. Beat addr 800 (DEPTH=800) → accepted, `vram_we` stays 0, `drop_count` goes 0→1. 300 such beats → `drop_count=255`.
- Gating and reset.
  - `wr_allow=0` for 4 cycles mid-burst → no `req_ready` and no `vram_we`; the burst completes after `wr_allow` returns.
  - `rst` pulsed mid-burst → `busy=0` and `vram_we=0` immediately.

Source files
------------

// File: rtl/osd_vram_wr_arbiter_if.sv
// Requester/VRAM bus of the OSD character-VRAM write arbiter.
// The slave modport is the arbiter side; the master modport is the writer/VRAM side.
interface osd_vram_wr_arbiter_if #(
  parameter int NUM_REQ = 3
);
  localparam int OW = $clog2(NUM_REQ);

  logic                 wr_allow;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*16-1:0] req_addr;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic                 vram_we;
  logic [15:0]          vram_addr;
  logic [7:0]           vram_data;
  logic                 busy;
  logic [OW-1:0]        owner;
  logic [7:0]           drop_count;

  modport slave (
    input  wr_allow, req_valid, req_addr, req_data, req_last,
    output req_ready, vram_we, vram_addr, vram_data, busy, owner, drop_count
  );

  modport master (
    output wr_allow, req_valid, req_addr, req_data, req_last,
    input  req_ready, vram_we, vram_addr, vram_data, busy, owner, drop_count
  );
endinterface

// File: rtl/osd_vram_wr_arbiter.sv
// OSD VRAM write-port arbiter: requester 0 fixed priority, others round-robin,
// locked bursts ending on last, gated by wr_allow, out-of-range beats dropped.
module osd_vram_wr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int COLS    = 40,
  parameter int ROWS    = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  osd_vram_wr_arbiter_if.slave   bus
);
  localparam int          DEPTH = COLS * ROWS;
  localparam int          OW    = $clog2(NUM_REQ);
  localparam int unsigned NR    = NUM_REQ;

  typedef enum logic {S_IDLE, S_LOCK} state_t;

  state_t             r_state, w_next_state;
  logic [OW-1:0]      r_owner, r_rr_ptr;
  logic [OW-1:0]      w_winner, w_sel;
  logic               w_found;
  logic [NUM_REQ-1:0] w_ready;
  logic               w_acc, w_last, w_in_range;
  logic [15:0]        w_addr;
  logic [7:0]         w_data;
  logic               r_vram_we;
  logic [15:0]        r_vram_addr;
  logic [7:0]         r_vram_data;
  logic [7:0]         r_drop;

  // Idle winner: 0 first, else cyclic search from rr_ptr+1 over 1..NUM_REQ-1
  always_comb begin
    int unsigned c;
    c        = 0;
    w_winner = '0;
    w_found  = 1'b0;
    if (bus.req_valid[0]) begin
      w_found = 1'b1;
    end else begin
      for (int unsigned k = 1; k < NR; k++) begin
        c = 32'(r_rr_ptr) + k;
        if (c >= NR) c = c - (NR - 1);
        if (!w_found && bus.req_valid[c[OW-1:0]]) begin
          w_found  = 1'b1;
          w_winner = c[OW-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_acc && !w_last) w_next_state = S_LOCK;
      S_LOCK:  if (w_acc && w_last)  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_sel   = (r_state == S_LOCK) ? r_owner : w_winner;
    w_ready = '0;
    if (!rst && bus.wr_allow && (r_state == S_LOCK || w_found) && bus.req_valid[w_sel])
      w_ready[w_sel] = 1'b1;
  end

  assign w_acc      = |w_ready;
  assign w_last     = bus.req_last[w_sel];
  assign w_addr     = bus.req_addr[32'(w_sel)*16 +: 16];
  assign w_data     = bus.req_data[32'(w_sel)*8 +: 8];
  assign w_in_range = (w_addr < 16'(DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vram_we   <= 1'b0;
      r_vram_addr <= '0;
      r_vram_data <= '0;
      r_owner     <= '0;
      r_rr_ptr    <= '0;
      r_drop      <= '0;
    end else begin
      r_vram_we <= w_acc && w_in_range;
      if (w_acc) begin
        r_owner <= w_sel;
        if (w_in_range) begin
          r_vram_addr <= w_addr;
          r_vram_data <= w_data;
        end else if (r_drop != '1) begin
          r_drop <= r_drop + 8'd1;
        end
        if (w_last && w_sel != '0) r_rr_ptr <= w_sel;
      end
    end
  end

  assign bus.req_ready  = w_ready;
  assign bus.vram_we    = r_vram_we;
  assign bus.vram_addr  = r_vram_addr;
  assign bus.vram_data  = r_vram_data;
  assign bus.busy       = (r_state == S_LOCK);
  assign bus.owner      = r_owner;
  assign bus.drop_count = r_drop;
endmodule

// File: tb/tb_osd_vram_wr_arbiter.sv
// Bench for osd_vram_wr_arbiter: vector table, directed corner sequences,
// and randomized traffic against a rule-level reference model.
module tb_osd_vram_wr_arbiter;
  localparam int N     = 3;
  localparam int DEPTH = 800;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  osd_vram_wr_arbiter_if #(.NUM_REQ(N)) bus ();

  osd_vram_wr_arbiter #(.NUM_REQ(N), .COLS(40), .ROWS(20)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input int i, input logic v, input logic l,
                       input logic [15:0] a, input logic [7:0] d);
    bus.req_valid[i]        = v;
    bus.req_last[i]         = l;
    bus.req_addr[16*i +: 16] = a;
    bus.req_data[8*i +: 8]  = d;
  endtask

  typedef struct {
    logic        allow;
    logic [2:0]  valid;
    logic [2:0]  last;
    logic [15:0] addr;
    logic [2:0]  exp_ready;
    logic        exp_we;
    logic        exp_busy;
    logic [1:0]  exp_owner;
    logic [7:0]  exp_drop;
  } vec_t;

  vec_t vt[10];

  // reference model state
  bit          m_lock;
  int          m_owner, m_rr, m_drop;
  logic [15:0] m_addr;
  logic [7:0]  m_data;

  initial begin
    int we_seen;
    logic [2:0] exp_rdy;
    int win;
    logic [7:0] owner_data;

    vt[0] = '{1'b1, 3'b010, 3'b000, 16'd5,   3'b010, 1'b1, 1'b1, 2'd1, 8'd0};
    vt[1] = '{1'b1, 3'b011, 3'b000, 16'd6,   3'b010, 1'b1, 1'b1, 2'd1, 8'd0};
    vt[2] = '{1'b0, 3'b011, 3'b010, 16'd7,   3'b000, 1'b0, 1'b1, 2'd1, 8'd0};
    vt[3] = '{1'b1, 3'b011, 3'b010, 16'd7,   3'b010, 1'b1, 1'b0, 2'd1, 8'd0};
    vt[4] = '{1'b1, 3'b101, 3'b101, 16'd10,  3'b001, 1'b1, 1'b0, 2'd0, 8'd0};
    vt[5] = '{1'b1, 3'b100, 3'b100, 16'd11,  3'b100, 1'b1, 1'b0, 2'd2, 8'd0};
    vt[6] = '{1'b1, 3'b110, 3'b110, 16'd12,  3'b010, 1'b1, 1'b0, 2'd1, 8'd0};
    vt[7] = '{1'b1, 3'b110, 3'b110, 16'd13,  3'b100, 1'b1, 1'b0, 2'd2, 8'd0};
    vt[8] = '{1'b1, 3'b010, 3'b010, 16'd800, 3'b010, 1'b0, 1'b0, 2'd1, 8'd1};
    vt[9] = '{1'b1, 3'b000, 3'b000, 16'd14,  3'b000, 1'b0, 1'b0, 2'd1, 8'd1};

    // reset state, with all requesters asserting valid
    bus.wr_allow = 1'b1;
    for (int i = 0; i < N; i++) drive(i, 1'b1, 1'b1, 16'd1, 8'hAA);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", 32'(bus.req_ready), 0);
    chk("reset_we", 32'(bus.vram_we), 0);
    chk("reset_addr", 32'(bus.vram_addr), 0);
    chk("reset_data", 32'(bus.vram_data), 0);
    chk("reset_busy", 32'(bus.busy), 0);
    chk("reset_owner", 32'(bus.owner), 0);
    chk("reset_drop", 32'(bus.drop_count), 0);
    @(negedge clk);
    for (int i = 0; i < N; i++) drive(i, 1'b0, 1'b0, 16'd0, 8'd0);
    rst = 1'b0;

    // single writer: requester 1, three beats
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      drive(1, 1'b1, b == 2, 16'(5 + b), 8'(8'h41 + b));
      #1 chk("single_ready", 32'(bus.req_ready), 32'b010);
      @(posedge clk); #1;
      chk("single_we", 32'(bus.vram_we), 1);
      chk("single_addr", 32'(bus.vram_addr), 5 + b);
      chk("single_data", 32'(bus.vram_data), 8'h41 + b);
      chk("single_busy", 32'(bus.busy), (b < 2) ? 1 : 0);
    end
    @(negedge clk);
    drive(1, 1'b0, 1'b0, 16'd0, 8'd0);
    @(posedge clk); #1 chk("single_we_after", 32'(bus.vram_we), 0);

    // vector table: lock, gating, priority, round-robin, out-of-range
    for (int v = 0; v < 10; v++) begin
      @(negedge clk);
      bus.wr_allow = vt[v].allow;
      for (int i = 0; i < N; i++)
        drive(i, vt[v].valid[i], vt[v].last[i], vt[v].addr, vt[v].addr[7:0] ^ 8'(i));
      #1 chk($sformatf("vec%0d_ready", v), 32'(bus.req_ready), 32'(vt[v].exp_ready));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_we", v), 32'(bus.vram_we), 32'(vt[v].exp_we));
      chk($sformatf("vec%0d_busy", v), 32'(bus.busy), 32'(vt[v].exp_busy));
      chk($sformatf("vec%0d_owner", v), 32'(bus.owner), 32'(vt[v].exp_owner));
      chk($sformatf("vec%0d_drop", v), 32'(bus.drop_count), 32'(vt[v].exp_drop));
      if (vt[v].exp_we) begin
        owner_data = vt[v].addr[7:0] ^ 8'(vt[v].exp_owner);
        chk($sformatf("vec%0d_addr", v), 32'(bus.vram_addr), 32'(vt[v].addr));
        chk($sformatf("vec%0d_data", v), 32'(bus.vram_data), 32'(owner_data));
      end
    end

    // wr_allow low for 4 cycles in the middle of a requester-2 burst
    @(negedge clk);
    bus.wr_allow = 1'b1;
    drive(2, 1'b1, 1'b0, 16'd20, 8'h55);
    #1 chk("gate_first_ready", 32'(bus.req_ready), 32'b100);
    @(posedge clk); #1;
    chk("gate_first_we", 32'(bus.vram_we), 1);
    chk("gate_first_busy", 32'(bus.busy), 1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      bus.wr_allow = 1'b0;
      drive(0, 1'b1, 1'b1, 16'd30, 8'h11);
      #1 chk("gate_ready", 32'(bus.req_ready), 0);
      @(posedge clk); #1;
      chk("gate_we", 32'(bus.vram_we), 0);
      chk("gate_busy", 32'(bus.busy), 1);
    end
    @(negedge clk);
    bus.wr_allow = 1'b1;
    drive(2, 1'b1, 1'b1, 16'd21, 8'h56);
    #1 chk("gate_last_ready", 32'(bus.req_ready), 32'b100);
    @(posedge clk); #1;
    chk("gate_last_we", 32'(bus.vram_we), 1);
    chk("gate_last_addr", 32'(bus.vram_addr), 21);
    chk("gate_last_busy", 32'(bus.busy), 0);
    @(negedge clk);
    for (int i = 0; i < N; i++) drive(i, 1'b0, 1'b0, 16'd0, 8'd0);

    // drop counter saturation (starts at 1 from the table)
    we_seen = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      drive(1, 1'b1, 1'b1, 16'(DEPTH + (k % 3)), 8'hEE);
      @(posedge clk); #1;
      if (bus.vram_we) we_seen++;
    end
    @(negedge clk);
    drive(1, 1'b0, 1'b0, 16'd0, 8'd0);
    chk("oor_we_count", 32'(we_seen), 0);
    chk("oor_drop_sat", 32'(bus.drop_count), 255);

    // reset in the middle of a burst
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 16'd40, 8'h77);
    @(posedge clk); #1;
    chk("rst_pre_busy", 32'(bus.busy), 1);
    chk("rst_pre_we", 32'(bus.vram_we), 1);
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 16'd41, 8'h78);
    rst = 1'b1;
    #1;
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_we", 32'(bus.vram_we), 0);
    chk("rst_ready", 32'(bus.req_ready), 0);
    chk("rst_drop", 32'(bus.drop_count), 0);
    @(negedge clk);
    drive(1, 1'b0, 1'b0, 16'd0, 8'd0);
    rst = 1'b0;

    // randomized traffic against the rule-level model
    m_lock = 0; m_owner = 0; m_rr = 0; m_drop = 0; m_addr = '0; m_data = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      logic [15:0] a[N];
      logic [7:0]  d[N];
      logic        vv[N];
      logic        ll[N];
      logic        allow;
      @(negedge clk);
      allow = ($urandom_range(0, 7) != 0);
      bus.wr_allow = allow;
      for (int i = 0; i < N; i++) begin
        vv[i] = $urandom_range(0, 1);
        ll[i] = ($urandom_range(0, 2) == 0);
        a[i]  = ($urandom_range(0, 9) == 0) ? 16'(DEPTH + $urandom_range(0, 200))
                                             : 16'($urandom_range(0, DEPTH - 1));
        d[i]  = 8'($urandom);
        drive(i, vv[i], ll[i], a[i], d[i]);
      end
      win = -1;
      if (allow) begin
        if (m_lock) begin
          if (vv[m_owner]) win = m_owner;
        end else if (vv[0]) begin
          win = 0;
        end else begin
          for (int k = 1; k < N; k++) begin
            int c;
            c = ((m_rr + k - 1) % (N - 1)) + 1;
            if (win < 0 && vv[c]) win = c;
          end
        end
      end
      exp_rdy = (win >= 0) ? 3'(1 << win) : 3'b000;
      #1 chk("rand_ready", 32'(bus.req_ready), 32'(exp_rdy));
      if (win >= 0) begin
        m_owner = win;
        if (a[win] < DEPTH) begin
          m_addr = a[win];
          m_data = d[win];
        end else if (m_drop < 255) begin
          m_drop++;
        end
        if (ll[win]) begin
          m_lock = 0;
          if (win != 0) m_rr = win;
        end else begin
          m_lock = 1;
        end
      end
      @(posedge clk); #1;
      chk("rand_we", 32'(bus.vram_we), (win >= 0 && a[win] < DEPTH) ? 1 : 0);
      chk("rand_addr", 32'(bus.vram_addr), 32'(m_addr));
      chk("rand_data", 32'(bus.vram_data), 32'(m_data));
      chk("rand_busy", 32'(bus.busy), 32'(m_lock));
      chk("rand_owner", 32'(bus.owner), m_owner);
      chk("rand_drop", 32'(bus.drop_count), m_drop);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
